// File: rtl/sift_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : sift_pkg                                               |
// | Description : Widths, defaults and helpers shared by the SIFT        |
// |               Hessian, DoG and keypoint edge-filter stages.          |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
package sift_pkg;

  // Signed sample width used by the DoG and Hessian stages
  localparam int DATA_W              = 9;

  // Default thresholds for the keypoint filter
  localparam int R_DEFAULT           = 10;
  localparam int CONTRAST_TH_DEFAULT = 3;

  // Derived widths: trace, determinant, ratio terms and common compare
  localparam int TR_W  = DATA_W + 1;      // 10
  localparam int DET_W = 2 * DATA_W + 1;  // 19
  localparam int LHS_W = 23;              // tr^2 * R, R <= 15
  localparam int RHS_W = 27;              // det * (R+1)^2, signed
  localparam int CMP_W = 32;

  // Flags carried alongside each candidate through the pipeline
  typedef struct packed {
    logic valid;
    logic ext;
    logic contrast_ok;
  } side_t;

  // Absolute value widened by one bit so that the most negative input
  // (-256) maps to +256 instead of wrapping
  function automatic logic [TR_W-1:0] abs_ext(input logic signed [DATA_W-1:0] v);
    logic [TR_W-1:0] wide;
    wide = {v[DATA_W-1], v};
    return v[DATA_W-1] ? (~wide + TR_W'(1)) : wide;
  endfunction

endpackage
`default_nettype wire

// File: rtl/keypoint_edge_filter_edge_ratio_calc.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : edge_ratio_calc                                        |
// | Description : Two-stage datapath for the principal-curvature test:   |
// |               S1 trace/determinant, S2 tr^2*R and det*(R+1)^2.       |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module edge_ratio_calc
  import sift_pkg::*;
#(
  parameter int R = R_DEFAULT
) (
  input  logic                     iclk,
  input  logic                     irst_n,
  input  logic signed [DATA_W-1:0] dxx_i,
  input  logic signed [DATA_W-1:0] dyy_i,
  input  logic signed [DATA_W-1:0] dxy_i,
  output logic        [LHS_W-1:0]  lhs_o,
  output logic signed [RHS_W-1:0]  rhs_o,
  output logic                     det_pos_o
);

  localparam logic        [LHS_W-1:0] c_R_EXT = LHS_W'(R);
  localparam logic signed [RHS_W-1:0] c_R1_SQ = RHS_W'((R + 1) * (R + 1));

  logic signed [TR_W-1:0]     tr_d,  tr_q;
  logic signed [DET_W-1:0]    det_d, det_q;
  logic signed [2*DATA_W-1:0] w_p_xx_yy, w_p_xy_xy;
  logic signed [2*TR_W-1:0]   w_tr_sq;
  logic        [LHS_W-1:0]    lhs_d, lhs_q;
  logic signed [RHS_W-1:0]    rhs_d, rhs_q;
  logic                       det_pos_d, det_pos_q;

  // S1: trace and determinant; 18-bit products fit exactly, the extra
  // determinant bit absorbs the subtraction
  assign tr_d      = {dxx_i[DATA_W-1], dxx_i} + {dyy_i[DATA_W-1], dyy_i};
  assign w_p_xx_yy = dxx_i * dyy_i;
  assign w_p_xy_xy = dxy_i * dxy_i;
  assign det_d     = DET_W'(w_p_xx_yy) - DET_W'(w_p_xy_xy);

  // S2: both sides of tr^2*R < det*(R+1)^2; tr^2 is never negative
  assign w_tr_sq   = tr_q * tr_q;
  assign lhs_d     = LHS_W'($unsigned(w_tr_sq)) * c_R_EXT;
  assign rhs_d     = RHS_W'(det_q) * c_R1_SQ;
  assign det_pos_d = !det_q[DET_W-1] && (det_q != '0);

  // Pipeline registers for S1 and S2
  always_ff @(posedge iclk or negedge irst_n) begin
    if (!irst_n) begin
      tr_q      <= '0;
      det_q     <= '0;
      lhs_q     <= '0;
      rhs_q     <= '0;
      det_pos_q <= 1'b0;
    end else begin
      tr_q      <= tr_d;
      det_q     <= det_d;
      lhs_q     <= lhs_d;
      rhs_q     <= rhs_d;
      det_pos_q <= det_pos_d;
    end
  end

  assign lhs_o     = lhs_q;
  assign rhs_o     = rhs_q;
  assign det_pos_o = det_pos_q;

endmodule
`default_nettype wire

// File: rtl/keypoint_edge_filter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : keypoint_edge_filter                                   |
// | Description : SIFT low-contrast and edge-response rejection with a   |
// |               3-cycle pipeline and saturating per-frame keep count.  |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module keypoint_edge_filter
  import sift_pkg::*;
#(
  parameter int R           = R_DEFAULT,
  parameter int CONTRAST_TH = CONTRAST_TH_DEFAULT,
  parameter int X_W         = 10,
  parameter int Y_W         = 10,
  parameter int CNT_W       = 12
) (
  input  logic                     iclk,
  input  logic                     irst_n,
  input  logic                     ivalid,
  input  logic                     iframe_start,
  input  logic                     iextremum,
  input  logic signed [DATA_W-1:0] iData_mid,
  input  logic signed [DATA_W-1:0] idxx,
  input  logic signed [DATA_W-1:0] idyy,
  input  logic signed [DATA_W-1:0] idxy,
  input  logic        [X_W-1:0]    ix,
  input  logic        [Y_W-1:0]    iy,
  output logic                     ovalid,
  output logic                     okeep,
  output logic        [X_W-1:0]    ox,
  output logic        [Y_W-1:0]    oy,
  output logic        [CNT_W-1:0]  okp_count,
  output logic                     okp_sat
);

  side_t                     s1_side_d, s1_side_q, s2_side_q;
  logic        [X_W-1:0]     s1_x_q, s2_x_q;
  logic        [Y_W-1:0]     s1_y_q, s2_y_q;
  logic        [LHS_W-1:0]   w_lhs;
  logic signed [RHS_W-1:0]   w_rhs;
  logic                      w_det_pos;
  logic signed [CMP_W-1:0]   w_lhs_cmp, w_rhs_cmp;
  logic                      okeep_d, ovalid_q, okeep_q;
  logic        [X_W-1:0]     ox_q;
  logic        [Y_W-1:0]     oy_q;
  logic        [CNT_W-1:0]   okp_count_d, okp_count_q;
  logic                      okp_sat_d, okp_sat_q;
  logic                      w_count_keep;

  edge_ratio_calc #(
    .R (R)
  ) u_edge_ratio_calc (
    .iclk      (iclk),
    .irst_n    (irst_n),
    .dxx_i     (idxx),
    .dyy_i     (idyy),
    .dxy_i     (idxy),
    .lhs_o     (w_lhs),
    .rhs_o     (w_rhs),
    .det_pos_o (w_det_pos)
  );

  assign s1_side_d.valid       = ivalid;
  assign s1_side_d.ext         = iextremum;
  assign s1_side_d.contrast_ok = abs_ext(iData_mid) >= TR_W'(CONTRAST_TH);

  // Sideband and coordinates travel in lockstep with the ratio datapath
  always_ff @(posedge iclk or negedge irst_n) begin
    if (!irst_n) begin
      s1_side_q <= '0;
      s2_side_q <= '0;
      s1_x_q    <= '0;
      s2_x_q    <= '0;
      s1_y_q    <= '0;
      s2_y_q    <= '0;
    end else begin
      s1_side_q <= s1_side_d;
      s2_side_q <= s1_side_q;
      s1_x_q    <= ix;
      s2_x_q    <= s1_x_q;
      s1_y_q    <= iy;
      s2_y_q    <= s1_y_q;
    end
  end

  // S3 compare at a common signed width; strict less-than so ties reject
  assign w_lhs_cmp = {{(CMP_W - LHS_W){1'b0}}, w_lhs};
  assign w_rhs_cmp = {{(CMP_W - RHS_W){w_rhs[RHS_W-1]}}, w_rhs};
  assign okeep_d   = s2_side_q.valid & s2_side_q.ext & s2_side_q.contrast_ok
                   & w_det_pos & (w_lhs_cmp < w_rhs_cmp);

  // Output stage
  always_ff @(posedge iclk or negedge irst_n) begin
    if (!irst_n) begin
      ovalid_q <= 1'b0;
      okeep_q  <= 1'b0;
      ox_q     <= '0;
      oy_q     <= '0;
    end else begin
      ovalid_q <= s2_side_q.valid;
      okeep_q  <= okeep_d;
      ox_q     <= s2_x_q;
      oy_q     <= s2_y_q;
    end
  end

  assign w_count_keep = ovalid_q & okeep_q;

  // Counter next state: frame clear wins, a coincident keep opens the new frame
  always_comb begin
    okp_count_d = okp_count_q;
    okp_sat_d   = okp_sat_q;
    if (iframe_start) begin
      okp_count_d = w_count_keep ? CNT_W'(1) : '0;
      okp_sat_d   = 1'b0;
    end else if (w_count_keep) begin
      if (&okp_count_q) begin
        okp_sat_d = 1'b1;
      end else begin
        okp_count_d = okp_count_q + CNT_W'(1);
      end
    end
  end

  // Counter registers
  always_ff @(posedge iclk or negedge irst_n) begin
    if (!irst_n) begin
      okp_count_q <= '0;
      okp_sat_q   <= 1'b0;
    end else begin
      okp_count_q <= okp_count_d;
      okp_sat_q   <= okp_sat_d;
    end
  end

  assign ovalid    = ovalid_q;
  assign okeep     = okeep_q;
  assign ox        = ox_q;
  assign oy        = oy_q;
  assign okp_count = okp_count_q;
  assign okp_sat   = okp_sat_q;

endmodule
`default_nettype wire

// File: tb/tb_keypoint_edge_filter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : tb_keypoint_edge_filter                                |
// | Description : Directed self-checking bench; a default instance and a |
// |               2-bit-counter instance share the same stimulus.        |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module tb_keypoint_edge_filter;

  logic             iclk = 1'b0;
  logic             irst_n;
  logic             ivalid, iframe_start, iextremum;
  logic signed [8:0] iData_mid, idxx, idyy, idxy;
  logic [9:0]       ix, iy;

  logic             ovalid0, okeep0, okp_sat0;
  logic [9:0]       ox0, oy0;
  logic [11:0]      okp_count0;
  logic             ovalid1, okeep1, okp_sat1;
  logic [9:0]       ox1, oy1;
  logic [1:0]       okp_count1;

  int total = 0;
  int bad   = 0;
  int c0    = 0;   // model of the 12-bit counter
  int c1    = 0;   // model of the 2-bit counter
  int s1    = 0;   // model of the 2-bit saturation flag

  always #5 iclk = ~iclk;

  keypoint_edge_filter u_dut0 (
    .iclk(iclk), .irst_n(irst_n), .ivalid(ivalid), .iframe_start(iframe_start),
    .iextremum(iextremum), .iData_mid(iData_mid), .idxx(idxx), .idyy(idyy),
    .idxy(idxy), .ix(ix), .iy(iy), .ovalid(ovalid0), .okeep(okeep0),
    .ox(ox0), .oy(oy0), .okp_count(okp_count0), .okp_sat(okp_sat0)
  );

  keypoint_edge_filter #(.CNT_W(2)) u_dut1 (
    .iclk(iclk), .irst_n(irst_n), .ivalid(ivalid), .iframe_start(iframe_start),
    .iextremum(iextremum), .iData_mid(iData_mid), .idxx(idxx), .idyy(idyy),
    .idxy(idxy), .ix(ix), .iy(iy), .ovalid(ovalid1), .okeep(okeep1),
    .ox(ox1), .oy(oy1), .okp_count(okp_count1), .okp_sat(okp_sat1)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    total++;
    assert (obs === exp_v) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
    end
  endtask

  task automatic step();
    @(posedge iclk);
    #1;
  endtask

  task automatic drive(input logic v, input logic e, input int mid, input int dxx,
                       input int dyy, input int dxy, input int x, input int y);
    ivalid    = v;
    iextremum = e;
    iData_mid = 9'(mid);
    idxx      = 9'(dxx);
    idyy      = 9'(dyy);
    idxy      = 9'(dxy);
    ix        = 10'(x);
    iy        = 10'(y);
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic bump_model();
    c0++;
    if (c1 == 3) s1 = 1;
    else c1++;
  endtask

  task automatic check_counts(input string tag);
    check({tag, ".cnt0"}, 32'(okp_count0), 32'(c0));
    check({tag, ".cnt1"}, 32'(okp_count1), 32'(c1));
    check({tag, ".sat1"}, 32'(okp_sat1), 32'(s1));
  endtask

  // Single candidate: result after the third edge, count one edge later
  task automatic one(input string tag, input logic e, input int mid, input int dxx,
                     input int dyy, input int dxy, input int x, input int y,
                     input logic exp_keep);
    drive(1'b1, e, mid, dxx, dyy, dxy, x, y);
    step();
    idle();
    step();
    check({tag, ".early_valid"}, 32'(ovalid0), 32'd0);
    step();
    check({tag, ".ovalid"}, 32'(ovalid0), 32'd1);
    check({tag, ".okeep"}, 32'(okeep0), 32'(exp_keep));
    check({tag, ".okeep1"}, 32'(okeep1), 32'(exp_keep));
    check({tag, ".ox"}, 32'(ox0), 32'(x));
    check({tag, ".oy"}, 32'(oy0), 32'(y));
    if (exp_keep) bump_model();
    step();
    check({tag, ".valid_drop"}, 32'(ovalid0), 32'd0);
    check_counts(tag);
  endtask

  initial begin
    int exp_c1 [5];
    int exp_s1 [5];
    exp_c1 = '{1, 2, 3, 3, 3};
    exp_s1 = '{0, 0, 0, 1, 1};

    irst_n       = 1'b0;
    iframe_start = 1'b0;
    idle();
    repeat (3) step();
    check("rst.ovalid", 32'(ovalid0), 32'd0);
    check("rst.okeep", 32'(okeep0), 32'd0);
    check("rst.ox", 32'(ox0), 32'd0);
    check("rst.oy", 32'(oy0), 32'd0);
    check("rst.cnt", 32'(okp_count0), 32'd0);
    check("rst.sat", 32'(okp_sat0), 32'd0);
    irst_n = 1'b1;
    step();

    // tr=20 lhs=4000, det=100 rhs=12100 -> keep
    one("pass",     1'b1,   50,   10,   10,    0,  5,  7, 1'b1);
    // tr=11 lhs=1210, det=10 rhs=1210 -> tie rejects
    one("equal",    1'b1,   50,   10,    1,    0, 11, 12, 1'b0);
    // lhs=102010 > rhs=12100
    one("edge",     1'b1,   50,  100,    1,    0, 13, 14, 1'b0);
    one("det_neg",  1'b1,   50,   10,  -10,    0, 15, 16, 1'b0);
    one("det_zero", 1'b1,   50, -256, -256, -256, 17, 18, 1'b0);
    one("low_con",  1'b1,    2,   10,   10,    0, 19, 20, 1'b0);
    // |-256| = 256 must not wrap negative
    one("mid_min",  1'b1, -256,   10,   10,    0, 21, 22, 1'b1);
    one("no_ext",   1'b0,   50,   10,   10,    0, 23, 24, 1'b0);

    // New frame with nothing on the output
    iframe_start = 1'b1;
    step();
    iframe_start = 1'b0;
    c0 = 0; c1 = 0; s1 = 0;
    check_counts("clr1");

    // Streaming: even candidates pass, odd ones fail the edge test
    for (int k = 0; k < 22; k++) begin
      if (k < 20) begin
        if (k % 2 == 0) drive(1'b1, 1'b1, 50, 10, 10, 0, k, 100 + k);
        else            drive(1'b1, 1'b1, 50, 100, 1, 0, k, 100 + k);
      end else begin
        idle();
      end
      step();
      if (k >= 2) begin
        check("strm.ovalid", 32'(ovalid0), 32'd1);
        check("strm.okeep", 32'(okeep0), 32'(((k - 2) % 2) == 0));
        check("strm.ox", 32'(ox0), 32'(k - 2));
      end
    end
    step();
    c0 = 10; c1 = 3; s1 = 1;
    check_counts("strm");

    // Saturation of the 2-bit counter
    iframe_start = 1'b1;
    step();
    iframe_start = 1'b0;
    c0 = 0; c1 = 0; s1 = 0;
    check_counts("clr2");
    for (int k = 0; k < 8; k++) begin
      if (k < 5) drive(1'b1, 1'b1, 50, 10, 10, 0, 30 + k, 40);
      else       idle();
      step();
      if (k >= 3) begin
        check("sat.cnt1", 32'(okp_count1), 32'(exp_c1[k-3]));
        check("sat.sat1", 32'(okp_sat1), 32'(exp_s1[k-3]));
      end
    end
    check("sat.cnt0", 32'(okp_count0), 32'd5);

    // Frame clear in the same cycle a keep is on the output
    drive(1'b1, 1'b1, 50, 10, 10, 0, 50, 60);
    step();
    idle();
    step();
    step();
    check("coin.keep", 32'(okeep0), 32'd1);
    iframe_start = 1'b1;
    step();
    iframe_start = 1'b0;
    c0 = 1; c1 = 1; s1 = 0;
    check_counts("coin");

    // Asynchronous reset with two candidates in flight
    drive(1'b1, 1'b1, 50, 10, 10, 0, 70, 71);
    step();
    drive(1'b1, 1'b1, 50, 10, 10, 0, 72, 73);
    step();
    idle();
    #2 irst_n = 1'b0;
    #1;
    check("arst.ovalid", 32'(ovalid0), 32'd0);
    check("arst.okeep", 32'(okeep0), 32'd0);
    check("arst.ox", 32'(ox0), 32'd0);
    check("arst.oy", 32'(oy0), 32'd0);
    check("arst.cnt0", 32'(okp_count0), 32'd0);
    check("arst.cnt1", 32'(okp_count1), 32'd0);
    @(posedge iclk);
    #3 irst_n = 1'b1;
    c0 = 0; c1 = 0; s1 = 0;
    for (int k = 0; k < 4; k++) begin
      step();
      check("arst.stale", 32'(ovalid0), 32'd0);
    end
    one("post_rst", 1'b1, 50, 10, 10, 0, 80, 81, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
